// File: rtl/mod_reduce_pkg.sv
// Shared types and helpers for the sequential modular reducer.
package mod_reduce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; used to size the bit counter.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = int'(i) + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_reduce_seq_adder.sv
// Modular adder: sum = (a + b) mod q for inputs a < q and b <= q.
module mod_adder #(
    parameter int BITWIDTH = 32
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic [BITWIDTH-1:0] q,
    output logic [BITWIDTH-1:0] sum
);

    logic [BITWIDTH:0] sum_ext;
    logic [BITWIDTH:0] q_ext;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign q_ext   = {1'b0, q};

    // Inputs bounded by q keep sum_ext below 2q, so one subtract is enough.
    always_comb begin
        sum = sum_ext[BITWIDTH-1:0];
        if (sum_ext >= q_ext) begin
            sum = BITWIDTH'(sum_ext - q_ext);
        end
    end

endmodule

// File: rtl/mod_reduce_seq.sv
// Bit-serial operand mod Q reducer, MSB first, valid/ready on both sides.
// Optional leading-zero skip enabled by defining MOD_REDUCE_SKIP_LZ_EN.
module mod_reduce_seq
    import mod_reduce_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int IN_WIDTH = 2 * BITWIDTH
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iValid,
    output logic                oReady,
    input  logic [IN_WIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iQ,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oData
);

    localparam int CNT_W = (clog2(IN_WIDTH) > 0) ? clog2(IN_WIDTH) : 1;

    state_t              state;
    state_t              state_next;
    logic [IN_WIDTH-1:0] shreg;
    logic [BITWIDTH-1:0] r;
    logic [BITWIDTH-1:0] q_lat;
    logic [BITWIDTH-1:0] r_plus_b;
    logic [BITWIDTH-1:0] r_next;
    logic [CNT_W-1:0]    cnt;
    logic                accept;

`ifdef MOD_REDUCE_SKIP_LZ_EN
    function automatic int unsigned msb_index(input logic [IN_WIDTH-1:0] value);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (value[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    int unsigned lead;
    assign lead = msb_index(iData);
`endif

    assign oReady = (state == IDLE);
    assign accept = iValid && oReady;

    // r < q_lat keeps r + bit within BITWIDTH bits.
    assign r_plus_b = r + BITWIDTH'(shreg[IN_WIDTH-1]);

    mod_adder #(
        .BITWIDTH(BITWIDTH)
    ) u_adder (
        .a  (r),
        .b  (r_plus_b),
        .q  (q_lat),
        .sum(r_next)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MOD_REDUCE_SKIP_LZ_EN
                    state_next = (iData == '0) ? DONE : RUN;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (iReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            shreg  <= '0;
            r      <= '0;
            q_lat  <= '0;
            cnt    <= '0;
            oData  <= '0;
            oValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_lat <= iQ;
                        r     <= '0;
`ifdef MOD_REDUCE_SKIP_LZ_EN
                        if (iData == '0) begin
                            shreg  <= '0;
                            cnt    <= '0;
                            oData  <= '0;
                            oValid <= 1'b1;
                        end else begin
                            shreg <= iData << (IN_WIDTH - 1 - lead);
                            cnt   <= CNT_W'(lead);
                        end
`else
                        shreg <= iData;
                        cnt   <= CNT_W'(IN_WIDTH - 1);
`endif
                    end
                end
                RUN: begin
                    r     <= r_next;
                    shreg <= shreg << 1;
                    if (cnt == '0) begin
                        oData  <= r_next;
                        oValid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                    end
                end
                default: oValid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Self-checking bench for mod_reduce_seq (BITWIDTH=8, IN_WIDTH=16).
module tb_mod_reduce_seq;

    localparam int BW = 8;
    localparam int IW = 16;

    logic          iClk;
    logic          iRstN;
    logic          iValid;
    logic          oReady;
    logic [IW-1:0] iData;
    logic [BW-1:0] iQ;
    logic          oValid;
    logic          iReady;
    logic [BW-1:0] oData;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [IW-1:0] d;
        logic [BW-1:0] q;
        logic [BW-1:0] exp;
        int            hold;
    } vec_t;

    vec_t vecs[8];

    mod_reduce_seq #(
        .BITWIDTH(BW),
        .IN_WIDTH(IW)
    ) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iValid(iValid),
        .oReady(oReady),
        .iData (iData),
        .iQ    (iQ),
        .oValid(oValid),
        .iReady(iReady),
        .oData (oData)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Edges from accept to oValid: the whole operand, or only its significant bits when skipping.
    function automatic int exp_latency(input logic [IW-1:0] d);
`ifdef MOD_REDUCE_SKIP_LZ_EN
        int m;
        if (d == '0) return 0;
        m = 0;
        for (int i = 0; i < IW; i++) if (d[i]) m = i;
        return m + 1;
`else
        return IW;
`endif
    endfunction

    task automatic txn(input logic [IW-1:0] d, input logic [BW-1:0] q,
                       input logic [BW-1:0] exp, input int hold, input string name);
        int lat;
        int waitc;
        logic ready_low;
        logic stable;
        waitc = 0;
        while (!oReady && waitc < 100) begin
            @(posedge iClk); #1;
            waitc++;
        end
        check({name, "_ready_in"}, 32'(oReady), 32'd1);
        iValid = 1'b1;
        iData  = d;
        iQ     = q;
        @(posedge iClk); #1;
        iValid = 1'b0;
        iData  = IW'($urandom);
        iQ     = BW'($urandom);
        lat = 0;
        ready_low = 1'b1;
        while (!oValid && lat < 100) begin
            if (oReady) ready_low = 1'b0;
            @(posedge iClk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_latency(d)));
        check({name, "_ready_low_run"}, 32'(ready_low), 32'd1);
        check({name, "_data"}, 32'(oData), 32'(exp));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge iClk); #1;
            if (!oValid || oData !== exp || oReady) stable = 1'b0;
        end
        check({name, "_hold_stable"}, 32'(stable), 32'd1);
        iReady = 1'b1;
        @(posedge iClk); #1;
        iReady = 1'b0;
        check({name, "_valid_drop"}, 32'(oValid), 32'd0);
        check({name, "_ready_back"}, 32'(oReady), 32'd1);
    endtask

    initial begin
        logic [IW-1:0] rd;
        logic [BW-1:0] rq;

        vecs[0] = '{16'h1234, 8'h61, 8'h04, 0};
        vecs[1] = '{16'hFFFF, 8'hFF, 8'h00, 0};
        vecs[2] = '{16'h0005, 8'hFB, 8'h05, 0};
        vecs[3] = '{16'hABCD, 8'h01, 8'h00, 0};
        vecs[4] = '{16'h00C8, 8'h07, 8'h04, 5};
        vecs[5] = '{16'h0005, 8'h03, 8'h02, 1};
        vecs[6] = '{16'h0000, 8'h2A, 8'h00, 0};
        vecs[7] = '{16'h8001, 8'h0A, 8'h09, 2};

        iRstN  = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iData  = '0;
        iQ     = '0;
        repeat (3) @(posedge iClk);
        #1;
        check("reset_valid", 32'(oValid), 32'd0);
        check("reset_data", 32'(oData), 32'd0);
        iRstN = 1'b1;
        @(posedge iClk); #1;
        check("reset_ready", 32'(oReady), 32'd1);

        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].d, vecs[i].q, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a run; leave a nonzero prior result so the clear is visible.
        txn(16'h1234, 8'h61, 8'h04, 0, "pre_reset");
        iValid = 1'b1;
        iData  = 16'hFFFF;
        iQ     = 8'h65;
        @(posedge iClk); #1;
        iValid = 1'b0;
        repeat (6) @(posedge iClk);
        #2;
        iRstN = 1'b0;
        #1;
        check("midrun_rst_valid", 32'(oValid), 32'd0);
        check("midrun_rst_data", 32'(oData), 32'd0);
        check("midrun_rst_ready", 32'(oReady), 32'd1);
        @(posedge iClk); #1;
        iRstN = 1'b1;
        @(posedge iClk); #1;
        check("post_rst_ready", 32'(oReady), 32'd1);
        check("post_rst_valid", 32'(oValid), 32'd0);
        txn(16'h0100, 8'h0D, 8'h09, 0, "post_rst");

        // Random operands and moduli against plain modulo arithmetic.
        for (int n = 0; n < 40; n++) begin
            rd = IW'($urandom);
            if ((n % 5) == 0) rd = rd >> $urandom_range(0, 15);
            rq = BW'($urandom_range(1, 255));
            txn(rd, rq, BW'(rd % {8'b0, rq}), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
